dense_layer_engine: RTL and testbench
=====================================

// Module: dense_layer_engine
// PURPOSE
//  Self-sequenced fixed-point dense (fully-connected) layer: out[j] = act(bias[j] + sum_i in[i]*W[i][j]).
//  LANES output neurons are computed in parallel per pass; results are drained serially through a valid/ready port.
//  Sits between the AXIS input buffer and the next layer / output buffer. Weight and bias LUTs are external.
// PARAMETERS
//  IN_COUNT   64  number of inputs per neuron
//  OUT_COUNT  10  number of output neurons; must be a multiple of LANES (elaboration-time error otherwise)
//  DATA_SIZE  16  signed two's-complement width of inputs, weights, biases and outputs
//  FRAC_SIZE  8   fractional bits of every operand (Q(DATA_SIZE-FRAC_SIZE).FRAC_SIZE)
//  LANES      2   parallel MAC lanes; GROUPS = OUT_COUNT/LANES passes
//  RELU       1   1: clamp negative results to 0 before saturation; 0: identity activation
// PORTS
//  clk        in   1                        clock, rising edge
//  rst        in   1                        asynchronous active-high reset
//  start      in   1                        start one full layer evaluation (sampled in IDLE only)
//  busy       out  1                        high from the cycle after start until done
//  done       out  1                        one-cycle pulse when the last output is accepted
//  inAdr      out  clog2(IN_COUNT)          input-buffer read address (1-cycle sync read)
//  inData     in   DATA_SIZE                input-buffer data, valid the cycle after inAdr
//  weightAdr  out  clog2(IN_COUNT*GROUPS)   = in_idx*GROUPS + group (1-cycle sync read)
//  weightData in   LANES*DATA_SIZE          lane k in bits [k*DATA_SIZE +: DATA_SIZE] = W[i][group*LANES+k]
//  biasAdr    out  clog2(GROUPS)            = group (1-cycle sync read)
//  biasData   in   LANES*DATA_SIZE          lane k = bias[group*LANES+k]
//  outValid   out  1                        result available
//  outReady   in   1                        consumer accepts when outValid & outReady
//  outAdr     out  clog2(OUT_COUNT)         = group*LANES + lane
//  outData    out  DATA_SIZE                activated, saturated result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all counters/accumulators 0; busy, done, outValid, all addresses, outData = 0.
//  FSM: IDLE -> MAC -> FLUSH -> BIAS -> DRAIN -> (MAC of next group | DONE) -> IDLE.
//   IDLE : on start: clear all LANES accumulators, in_idx=0, group=0 -> MAC. start in any other state is ignored.
//   MAC  : one address per cycle, in_idx 0..IN_COUNT-1; a 1-cycle delayed valid accumulates the returned pair.
//          At in_idx==IN_COUNT-1 -> FLUSH. biasAdr driven during FLUSH.
//   FLUSH: accumulate last product -> BIAS.
//   BIAS : acc[k] += bias[k] << FRAC_SIZE-aligned (sign-extended, no shift needed: same Q format) -> DRAIN, lane=0.
//   DRAIN: outValid=1, outAdr/outData for current lane held stable until outReady. On accept: lane++;
//          after lane LANES-1: if group==GROUPS-1 -> DONE else clear accumulators, group++, in_idx=0 -> MAC.
//   DONE : done=1 for exactly one cycle, busy=0 -> IDLE. New start accepted in IDLE the next cycle.
//  Latency with outReady tied high: done asserts GROUPS*(IN_COUNT+2+LANES)+1 cycles after the start cycle.
//  Arithmetic per lane: prod = signed(in)*signed(w), 2*DATA_SIZE bits; term = prod >>> FRAC_SIZE (arith, floor);
//   accumulator width ACC_SIZE = 2*DATA_SIZE + clog2(IN_COUNT)+1, sign-extended adds, never wraps.
//  Output: v = RELU ? max(acc,0) : acc; outData = clamp(v, -2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1).
//  outReady low in non-DRAIN states has no effect; outReady is ignored when outValid=0.
//  Addresses outside the active phase are held at 0 (no spurious reads of stale indices).
//  rst mid-operation abandons the pass; no partial done; outputs already accepted are not revoked.
// STRUCTURE
//  Shared package dense_pkg: FSM state encoding, ACC_SIZE function, sat/relu function, clog2 wrapper.
//  Sub-module dense_mac_lane (one per lane, generate loop): accumulator register with clr, acc_en,
//   bias_en; exposes acc. Top holds FSM, in_idx/group/lane counters, address generation, output mux.
// TESTING  (IN_COUNT=4, OUT_COUNT=4, LANES=2, DATA_SIZE=16, FRAC_SIZE=8 unless stated)
//  1 in=0x0100 (1.0) all, W=0x0080 (0.5) all, bias=0, outReady=1 -> outData 0x0200 at outAdr 0,1,2,3; done at cycle 17.
//  2 sum=-3.0 (in=0x0100, W=0xFF40), bias=0 -> RELU=1: 0x0000; RELU=0: 0xFD00; bias=0x0400 RELU=0 -> 0x0100.
//  3 in=W=0x7F00 -> 0x7FFF all outputs; in=0x7F00, W=0x8100, RELU=0 -> 0x8000 (saturate, no wrap).
//  4 outReady low 3 cycles on each DRAIN beat -> outValid/outAdr/outData stable, exactly 4 accepts in order 0..3.
//  5 rst pulsed mid-MAC of group 1 -> busy/outValid/done 0 same cycle; fresh start reproduces scenario 1 exactly.
//  6 start held high throughout -> ignored while busy; second evaluation begins the cycle after done.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared definitions for the dense layer engine: FSM encoding, width helpers
// and the activation/saturation function applied to every output.
package dense_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MAC   = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_BIAS  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Address width that never collapses to zero bits for single-entry spaces.
    function automatic int clog2w(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Accumulator width: full product plus enough headroom that summing every
    // input (and the bias) can never wrap.
    function automatic int accSize(input int dataSize, input int inCount);
        return 2 * dataSize + $clog2(inCount) + 1;
    endfunction

    // Optional ReLU followed by a clamp into the signed dataSize-bit range.
    function automatic logic signed [63:0] reluSat(input logic signed [63:0] value,
                                                   input int dataSize,
                                                   input bit useRelu);
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        logic signed [63:0] v;
        maxV = (64'sd1 <<< (dataSize - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (dataSize - 1));
        v = (useRelu && (value < 0)) ? 64'sd0 : value;
        if (v > maxV) begin
            v = maxV;
        end else if (v < minV) begin
            v = minV;
        end
        return v;
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One MAC lane: accumulates floor-scaled products of input and weight, then
// adds the bias, which already shares the accumulator's binary point.
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_SIZE = 8,
    parameter int ACC_SIZE  = 39
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       accEn,
    input  logic                       biasEn,
    input  logic [DATA_SIZE-1:0]       inData,
    input  logic [DATA_SIZE-1:0]       weight,
    input  logic [DATA_SIZE-1:0]       bias,
    output logic signed [ACC_SIZE-1:0] acc
);

    logic signed [2*DATA_SIZE-1:0] prod;
    logic signed [2*DATA_SIZE-1:0] term;
    logic signed [ACC_SIZE-1:0]    termExt;
    logic signed [ACC_SIZE-1:0]    biasExt;

    // Signed full-width product, rescaled with an arithmetic (flooring) shift.
    always_comb begin
        prod    = $signed({{DATA_SIZE{inData[DATA_SIZE-1]}}, inData})
                * $signed({{DATA_SIZE{weight[DATA_SIZE-1]}}, weight});
        term    = prod >>> FRAC_SIZE;
        termExt = {{(ACC_SIZE-2*DATA_SIZE){term[2*DATA_SIZE-1]}}, term};
        biasExt = {{(ACC_SIZE-DATA_SIZE){bias[DATA_SIZE-1]}}, bias};
    end

    // Accumulator: clear wins, then bias add, then product add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (biasEn) begin
            acc <= acc + biasExt;
        end else if (accEn) begin
            acc <= acc + termExt;
        end
    end

endmodule

// File: rtl/dense_layer_engine.sv
// Self-sequenced dense layer: LANES neurons per pass over all inputs, then
// bias, activation and saturation, results drained one lane at a time.
module dense_layer_engine
    import dense_pkg::*;
#(
    parameter int IN_COUNT  = 64,
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_SIZE = 8,
    parameter int LANES     = 2,
    parameter int RELU      = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic [clog2w(IN_COUNT)-1:0]                   inAdr,
    input  logic [DATA_SIZE-1:0]                          inData,
    output logic [clog2w(IN_COUNT*(OUT_COUNT/LANES))-1:0] weightAdr,
    input  logic [LANES*DATA_SIZE-1:0]                    weightData,
    output logic [clog2w(OUT_COUNT/LANES)-1:0]            biasAdr,
    input  logic [LANES*DATA_SIZE-1:0]                    biasData,
    output logic                                          outValid,
    input  logic                                          outReady,
    output logic [clog2w(OUT_COUNT)-1:0]                  outAdr,
    output logic [DATA_SIZE-1:0]                          outData
);

    localparam int GROUPS   = OUT_COUNT / LANES;
    localparam int IN_W     = clog2w(IN_COUNT);
    localparam int WADR_W   = clog2w(IN_COUNT * GROUPS);
    localparam int BADR_W   = clog2w(GROUPS);
    localparam int OADR_W   = clog2w(OUT_COUNT);
    localparam int LANE_W   = clog2w(LANES);
    localparam int ACC_SIZE = accSize(DATA_SIZE, IN_COUNT);

    if ((OUT_COUNT % LANES) != 0) begin : gBadLanes
        $error("dense_layer_engine: OUT_COUNT must be a multiple of LANES");
    end
    if (ACC_SIZE > 64) begin : gBadAcc
        $error("dense_layer_engine: accumulator wider than the 64-bit activation path");
    end

    logic [2:0]        state;
    logic [IN_W-1:0]   inIdx;
    logic [BADR_W-1:0] group;
    logic [LANE_W-1:0] lane;
    logic              macValid;
    logic              clrAcc;
    logic              biasEn;
    logic              lastLane;
    logic              lastGroup;
    logic signed [ACC_SIZE-1:0] accs [LANES];
    logic signed [ACC_SIZE-1:0] accSel;

    // Decode the pass boundaries and the lane control strobes.
    always_comb begin
        lastLane  = (lane == LANE_W'(LANES - 1));
        lastGroup = (group == BADR_W'(GROUPS - 1));
        biasEn    = (state == ST_BIAS);
        clrAcc    = ((state == ST_IDLE) && start)
                 || ((state == ST_DRAIN) && outReady && lastLane && !lastGroup);
    end

    // Sequencer: counters advance with the phase, start only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            inIdx    <= '0;
            group    <= '0;
            lane     <= '0;
            macValid <= 1'b0;
        end else begin
            macValid <= (state == ST_MAC);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_MAC;
                        inIdx <= '0;
                        group <= '0;
                        lane  <= '0;
                    end
                end
                ST_MAC: begin
                    if (inIdx == IN_W'(IN_COUNT - 1)) begin
                        state <= ST_FLUSH;
                        inIdx <= '0;
                    end else begin
                        inIdx <= inIdx + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_BIAS;
                end
                ST_BIAS: begin
                    state <= ST_DRAIN;
                    lane  <= '0;
                end
                ST_DRAIN: begin
                    if (outReady) begin
                        if (lastLane) begin
                            lane <= '0;
                            if (lastGroup) begin
                                state <= ST_DONE;
                                group <= '0;
                            end else begin
                                state <= ST_MAC;
                                group <= group + 1'b1;
                                inIdx <= '0;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : gLane
        dense_mac_lane #(
            .DATA_SIZE (DATA_SIZE),
            .FRAC_SIZE (FRAC_SIZE),
            .ACC_SIZE  (ACC_SIZE)
        ) uLane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clrAcc),
            .accEn  (macValid),
            .biasEn (biasEn),
            .inData (inData),
            .weight (weightData[k*DATA_SIZE +: DATA_SIZE]),
            .bias   (biasData[k*DATA_SIZE +: DATA_SIZE]),
            .acc    (accs[k])
        );
    end

    // Addresses are only live in their own phase so idle reads never see stale indices.
    always_comb begin
        inAdr     = '0;
        weightAdr = '0;
        biasAdr   = '0;
        if (state == ST_MAC) begin
            inAdr     = inIdx;
            weightAdr = WADR_W'(inIdx) * WADR_W'(GROUPS) + WADR_W'(group);
        end
        if (state == ST_FLUSH) begin
            biasAdr = group;
        end
    end

    // Status flags and the activated, saturated output of the current lane.
    always_comb begin
        busy     = (state == ST_MAC) || (state == ST_FLUSH)
                || (state == ST_BIAS) || (state == ST_DRAIN);
        done     = (state == ST_DONE);
        outValid = (state == ST_DRAIN);
        accSel   = accs[lane];
        outAdr   = '0;
        outData  = '0;
        if (state == ST_DRAIN) begin
            outAdr  = OADR_W'(group) * OADR_W'(LANES) + OADR_W'(lane);
            outData = DATA_SIZE'(reluSat({{(64-ACC_SIZE){accSel[ACC_SIZE-1]}}, accSel},
                                         DATA_SIZE, RELU != 0));
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Testbench for dense_layer_engine: two instances (ReLU on / off) share the
// stimulus and memories; a scoreboard queue per instance is checked by a monitor.
module tb_dense_layer_engine;

    localparam int IN_COUNT  = 4;
    localparam int OUT_COUNT = 4;
    localparam int LANES     = 2;
    localparam int GROUPS    = OUT_COUNT / LANES;

    logic        clk;
    logic        rst;
    logic        start;
    logic        outReady;

    logic        busyA, doneA, outValidA;
    logic [1:0]  inAdrA, outAdrA;
    logic [2:0]  weightAdrA;
    logic [0:0]  biasAdrA;
    logic [15:0] inDataA, outDataA;
    logic [31:0] weightDataA, biasDataA;

    logic        busyB, doneB, outValidB;
    logic [1:0]  inAdrB, outAdrB;
    logic [2:0]  weightAdrB;
    logic [0:0]  biasAdrB;
    logic [15:0] inDataB, outDataB;
    logic [31:0] weightDataB, biasDataB;

    logic [15:0] inMem   [IN_COUNT];
    logic [15:0] wMem    [IN_COUNT][OUT_COUNT];
    logic [15:0] biasMem [OUT_COUNT];

    typedef struct {
        logic [1:0]  adr;
        logic [15:0] data;
    } expT;

    expT expQA[$];
    expT expQB[$];

    int  compared;
    int  mismatched;
    int  holdCnt;
    bit  stallMode;
    bit  prevHeld;
    logic [1:0]  prevAdr;
    logic [15:0] prevData;

    dense_layer_engine #(
        .IN_COUNT(IN_COUNT), .OUT_COUNT(OUT_COUNT), .DATA_SIZE(16),
        .FRAC_SIZE(8), .LANES(LANES), .RELU(1)
    ) dutA (
        .clk(clk), .rst(rst), .start(start), .busy(busyA), .done(doneA),
        .inAdr(inAdrA), .inData(inDataA), .weightAdr(weightAdrA),
        .weightData(weightDataA), .biasAdr(biasAdrA), .biasData(biasDataA),
        .outValid(outValidA), .outReady(outReady), .outAdr(outAdrA), .outData(outDataA)
    );

    dense_layer_engine #(
        .IN_COUNT(IN_COUNT), .OUT_COUNT(OUT_COUNT), .DATA_SIZE(16),
        .FRAC_SIZE(8), .LANES(LANES), .RELU(0)
    ) dutB (
        .clk(clk), .rst(rst), .start(start), .busy(busyB), .done(doneB),
        .inAdr(inAdrB), .inData(inDataB), .weightAdr(weightAdrB),
        .weightData(weightDataB), .biasAdr(biasAdrB), .biasData(biasDataB),
        .outValid(outValidB), .outReady(outReady), .outAdr(outAdrB), .outData(outDataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] packW(input logic [2:0] adr);
        int i;
        int g;
        i = int'(adr) / GROUPS;
        g = int'(adr) % GROUPS;
        return {wMem[i][g*LANES+1], wMem[i][g*LANES]};
    endfunction

    function automatic logic [31:0] packB(input logic [0:0] adr);
        int g;
        g = int'(adr);
        return {biasMem[g*LANES+1], biasMem[g*LANES]};
    endfunction

    // Synchronous-read memories, one read port per instance.
    always @(posedge clk) begin
        inDataA     <= inMem[inAdrA];
        inDataB     <= inMem[inAdrB];
        weightDataA <= packW(weightAdrA);
        weightDataB <= packW(weightAdrB);
        biasDataA   <= packB(biasAdrA);
        biasDataB   <= packB(biasAdrB);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failEvent(input string name, input string what);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold stability.
    always @(negedge clk) begin
        expT e;
        if (!rst) begin
            if (outValidA && prevHeld) begin
                checkOutput("hold outAdr", 32'(outAdrA), 32'(prevAdr));
                checkOutput("hold outData", 32'(outDataA), 32'(prevData));
            end
            if (outValidA && outReady) begin
                if (expQA.size() == 0) begin
                    failEvent("accept A", "got unexpected beat, required none");
                end else begin
                    e = expQA.pop_front();
                    checkOutput("relu outAdr", 32'(outAdrA), 32'(e.adr));
                    checkOutput("relu outData", 32'(outDataA), 32'(e.data));
                end
            end
            if (outValidB && outReady) begin
                if (expQB.size() == 0) begin
                    failEvent("accept B", "got unexpected beat, required none");
                end else begin
                    e = expQB.pop_front();
                    checkOutput("linear outAdr", 32'(outAdrB), 32'(e.adr));
                    checkOutput("linear outData", 32'(outDataB), 32'(e.data));
                end
            end
            prevHeld = outValidA && !outReady;
            prevAdr  = outAdrA;
            prevData = outDataA;
        end else begin
            prevHeld = 1'b0;
        end
    end

    // Consumer: always ready, or in stall mode three low cycles before each accept.
    initial begin
        outReady = 1'b1;
        holdCnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!stallMode) begin
                outReady = 1'b1;
                holdCnt  = 0;
            end else if (outValidA) begin
                if (holdCnt < 3) begin
                    outReady = 1'b0;
                    holdCnt++;
                end else begin
                    outReady = 1'b1;
                    holdCnt  = 0;
                end
            end else begin
                outReady = 1'b0;
                holdCnt  = 0;
            end
        end
    end

    task automatic setUniform(input logic [15:0] inV, input logic [15:0] wV, input logic [15:0] bV);
        for (int i = 0; i < IN_COUNT; i++) begin
            inMem[i] = inV;
            for (int j = 0; j < OUT_COUNT; j++) wMem[i][j] = wV;
        end
        for (int j = 0; j < OUT_COUNT; j++) biasMem[j] = bV;
    endtask

    task automatic pushExp(input logic [63:0] expR, input logic [63:0] expL, input int count);
        expT e;
        for (int j = 0; j < count; j++) begin
            e.adr  = 2'(j);
            e.data = expR[j*16 +: 16];
            expQA.push_back(e);
            e.data = expL[j*16 +: 16];
            expQB.push_back(e);
        end
    endtask

    // Wait (bounded) for done; returns cycles since the start cycle, 0 on timeout.
    task automatic waitDone(input string name, input int firstN, output int n);
        n = firstN;
        while (!doneA && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!doneA) begin
            failEvent(name, "got no done pulse, required done within 400 cycles");
            n = 0;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [63:0] expR,
                                 input logic [63:0] expL, input int latency);
        int n;
        pushExp(expR, expL, OUT_COUNT);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, " busy after start"}, 32'(busyA), 32'd1);
        waitDone(name, 1, n);
        if (n != 0) begin
            checkOutput({name, " done latency"}, 32'(n), 32'(latency));
            checkOutput({name, " busy at done"}, 32'(busyA), 32'd0);
            checkOutput({name, " done B"}, 32'(doneB), 32'd1);
            @(negedge clk);
            checkOutput({name, " done width"}, 32'(doneA), 32'd0);
        end
        checkOutput({name, " beats left"}, 32'(expQA.size() + expQB.size()), 32'd0);
        expQA.delete();
        expQB.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit, required self-termination");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        stallMode  = 1'b0;
        prevHeld   = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        setUniform(16'h0100, 16'h0080, 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("reset busy/done/valid", {29'd0, busyA, doneA, outValidA}, 32'd0);
        checkOutput("reset addresses", {24'd0, inAdrA, weightAdrA, biasAdrA}, 32'd0);
        checkOutput("reset outAdr/outData", {14'd0, outAdrA, outDataA}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("s1 half", {4{16'h0200}}, {4{16'h0200}}, 17);
        setUniform(16'h0100, 16'hFF40, 16'h0000);
        applyStimulus("s2 neg", {4{16'h0000}}, {4{16'hFD00}}, 17);
        setUniform(16'h0100, 16'hFF40, 16'h0400);
        applyStimulus("s2 bias", {4{16'h0100}}, {4{16'h0100}}, 17);
        setUniform(16'h7F00, 16'h7F00, 16'h0000);
        applyStimulus("s3 sat hi", {4{16'h7FFF}}, {4{16'h7FFF}}, 17);
        setUniform(16'h7F00, 16'h8100, 16'h0000);
        applyStimulus("s3 sat lo", {4{16'h0000}}, {4{16'h8000}}, 17);
        setUniform(16'h0001, 16'hFF80, 16'h0000);
        applyStimulus("floor", {4{16'h0000}}, {4{16'hFFFC}}, 17);

        setUniform(16'h0100, 16'h0000, 16'h0000);
        for (int i = 0; i < IN_COUNT; i++)
            for (int j = 0; j < OUT_COUNT; j++) wMem[i][j] = 16'(16'h0100 * (j + 1));
        biasMem[1] = 16'hF400;
        biasMem[3] = 16'hE000;
        applyStimulus("columns",
                      {16'h0000, 16'h0C00, 16'h0000, 16'h0400},
                      {16'hF000, 16'h0C00, 16'hFC00, 16'h0400}, 17);

        stallMode = 1'b1;
        applyStimulus("stall",
                      {16'h0000, 16'h0C00, 16'h0000, 16'h0400},
                      {16'hF000, 16'h0C00, 16'hFC00, 16'h0400}, 29);
        stallMode = 1'b0;
        @(negedge clk);

        setUniform(16'h0100, 16'h0080, 16'h0000);
        pushExp({4{16'h0200}}, {4{16'h0200}}, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset busy/valid/done", {29'd0, busyA, outValidA, doneA}, 32'd0);
        checkOutput("mid reset inAdr", 32'(inAdrA), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid reset accepted beats", 32'(expQA.size() + expQB.size()), 32'd0);
        expQA.delete();
        expQB.delete();
        applyStimulus("after reset", {4{16'h0200}}, {4{16'h0200}}, 17);

        pushExp({4{16'h0200}}, {4{16'h0200}}, OUT_COUNT);
        pushExp({4{16'h0200}}, {4{16'h0200}}, OUT_COUNT);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        waitDone("held start 1", 1, n);
        if (n != 0) begin
            checkOutput("held start first done", 32'(n), 32'd17);
            @(negedge clk);
            checkOutput("held start idle gap", 32'(busyA), 32'd0);
            @(negedge clk);
            checkOutput("held start restart", 32'(busyA), 32'd1);
            start = 1'b0;
            waitDone("held start 2", 19, n);
            if (n != 0) checkOutput("held start second done", 32'(n), 32'd35);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("held start beats left", 32'(expQA.size() + expQB.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
